// File: rtl/arith_pkg.sv
// Shared widths, result types and flag helpers for the arithmetic datapath.
// Both the subtractor pipeline and its bench import this package.
package arith_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned BLOCK_DEFAULT = 4;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

    typedef struct packed {
        word_t diff;
        logic  borrow;
        logic  ovf;
    } sub_result_t;

    // Signed overflow of A - B: operands differ in sign and the result left A's sign.
    function automatic logic sub_signed_ovf(input logic sign_a, input logic sign_b,
                                            input logic sign_d);
        return (sign_a != sign_b) && (sign_d != sign_a);
    endfunction

endpackage

// File: rtl/csk_block.sv
// One carry-skip group: ripples internally, bypasses cin to cout when every bit propagates.
// The skip mux shortens the worst-case path without changing the arithmetic result.
module csk_block #(
    parameter int unsigned BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] gen;
    logic             all_prop;
    logic             ripple_c;

    assign prop     = a ^ b;
    assign gen      = a & b;
    assign all_prop = &prop;

    always_comb begin
        ripple_c = cin;
        s        = '0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            s[i]     = prop[i] ^ ripple_c;
            ripple_c = gen[i] | (prop[i] & ripple_c);
        end
    end

    assign cout = all_prop ? cin : ripple_c;

endmodule

// File: rtl/carry_skip_subtractor_pipe.sv
// Two-stage pipelined A - B (A + ~B + 1) built from carry-skip groups, low half then high half.
// Valid/ready on both sides; holds up to two results and never inserts bubbles under ready.
module carry_skip_subtractor_pipe
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned BLOCK = BLOCK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NB   = HALF / BLOCK;

    // Flow control
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_adv;
    logic in_fire;

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Stage 1 datapath: low half with carry-in of 1
    logic [WIDTH-1:0] sub_inv;
    logic [HALF-1:0]  lo_sum;
    logic             lo_cout;

    assign sub_inv = ~subtrahend;

    for (genvar i = 0; i < int'(NB); i++) begin : g_lo
        logic             cin_w;
        logic             cout_w;
        logic [BLOCK-1:0] s_w;

        if (i == 0) begin : g_first
            assign cin_w = 1'b1;
        end else begin : g_chain
            assign cin_w = g_lo[i-1].cout_w;
        end

        csk_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a   (minuend[i*BLOCK +: BLOCK]),
            .b   (sub_inv[i*BLOCK +: BLOCK]),
            .cin (cin_w),
            .s   (s_w),
            .cout(cout_w)
        );

        assign lo_sum[i*BLOCK +: BLOCK] = s_w;
    end

    assign lo_cout = g_lo[NB-1].cout_w;

    logic [HALF-1:0] lo_diff_q;
    logic            carry_q;
    logic [HALF-1:0] a_hi_q;
    logic [HALF-1:0] b_hi_inv_q;
    logic            sign_a_q;
    logic            sign_b_q;

    // Stage 2 datapath: high half fed from the stage-1 registers
    logic [HALF-1:0] hi_sum;
    logic            hi_cout;

    for (genvar i = 0; i < int'(NB); i++) begin : g_hi
        logic             cin_w;
        logic             cout_w;
        logic [BLOCK-1:0] s_w;

        if (i == 0) begin : g_first
            assign cin_w = carry_q;
        end else begin : g_chain
            assign cin_w = g_hi[i-1].cout_w;
        end

        csk_block #(
            .BLOCK(BLOCK)
        ) u_blk (
            .a   (a_hi_q[i*BLOCK +: BLOCK]),
            .b   (b_hi_inv_q[i*BLOCK +: BLOCK]),
            .cin (cin_w),
            .s   (s_w),
            .cout(cout_w)
        );

        assign hi_sum[i*BLOCK +: BLOCK] = s_w;
    end

    assign hi_cout = g_hi[NB-1].cout_w;

    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        diff_d   = {hi_sum, lo_diff_q};
        borrow_d = ~hi_cout;
        ovf_d    = sub_signed_ovf(sign_a_q, sign_b_q, hi_sum[HALF-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            lo_diff_q  <= '0;
            carry_q    <= 1'b0;
            a_hi_q     <= '0;
            b_hi_inv_q <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                lo_diff_q  <= lo_sum;
                carry_q    <= lo_cout;
                a_hi_q     <= minuend[WIDTH-1:HALF];
                b_hi_inv_q <= sub_inv[WIDTH-1:HALF];
                sign_a_q   <= minuend[WIDTH-1];
                sign_b_q   <= subtrahend[WIDTH-1];
            end
            // Loads only on advance, so the output holds steady while stalled
            if (s2_adv) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_carry_skip_subtractor_pipe.sv
// Scoreboard bench for the pipelined carry-skip subtractor: directed corner cases,
// backpressure, reset flush and a randomised run with random downstream stalls.
module tb_carry_skip_subtractor_pipe;
    import arith_pkg::*;

    logic  clk;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    word_t minuend;
    word_t subtrahend;
    logic  out_valid;
    logic  out_ready;
    word_t diff;
    logic  borrow_out;
    logic  overflow;

    int n_tests;
    int n_fail;
    bit rand_done;

    sub_result_t sb_q[$];
    sub_result_t exp_r;

    carry_skip_subtractor_pipe #(
        .WIDTH(WIDTH_DEFAULT),
        .BLOCK(BLOCK_DEFAULT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .minuend   (minuend),
        .subtrahend(subtrahend),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic sub_result_t ref_model(input word_t a, input word_t b);
        sub_result_t r;
        r.diff   = a - b;
        r.borrow = (a < b);
        r.ovf    = (a[31] ^ b[31]) & (r.diff[31] ^ a[31]);
        return r;
    endfunction

    // Transfers are judged mid-cycle; they complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("spurious_out", 64'd1, 64'd0);
                end else begin
                    exp_r = sb_q.pop_front();
                    check_val("diff", 64'(diff), 64'(exp_r.diff));
                    check_val("borrow", 64'(borrow_out), 64'(exp_r.borrow));
                    check_val("overflow", 64'(overflow), 64'(exp_r.ovf));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_model(minuend, subtrahend));
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input word_t a, input word_t b);
        bit ok;
        int n;
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        ok = 1'b0;
        n  = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 500);
        in_valid = 1'b0;
        if (!ok) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("drain", 64'(sb_q.size()), 64'd0);
    endtask

    function automatic word_t pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rand_done  = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_diff", 64'(diff), 64'd0);
        check_val("rst_borrow", 64'(borrow_out), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted on edge E0, visible after E1
        send(32'd5, 32'd3);
        @(negedge clk);
        check_val("lat_s1_only", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("lat_out_valid", 64'(out_valid), 64'd1);
        check_val("lat_diff", 64'(diff), 64'h2);
        @(posedge clk);
        #1;

        send(32'h0000_0000, 32'h0000_0001);
        send(32'h8000_0000, 32'h0000_0001);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        send(32'h0001_0000, 32'h0000_0001);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // Backpressure: two accepted, third held off while the output stalls
        out_ready = 1'b0;
        send(32'd10, 32'd1);
        send(32'd20, 32'd2);
        in_valid   = 1'b1;
        minuend    = 32'd30;
        subtrahend = 32'd3;
        repeat (5) begin
            @(negedge clk);
            check_val("bp_in_ready", 64'(in_ready), 64'd0);
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_val("bp_diff_hold", 64'(diff), 64'd9);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'd30, 32'd3);
        drain();

        // Reset with two results in flight: nothing stale may appear afterwards
        out_ready = 1'b0;
        send(32'd100, 32'd1);
        send(32'd200, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("flush_out_valid", 64'(out_valid), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("flush_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick_operand(), pick_operand());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
